// File: rtl/prio_pkg.sv
// rtl/prio_pkg.sv - shared helpers for prio_grant_reg (width calc, popcount)
package prio_pkg;

  // Widest request vector the popcount helper supports.
  localparam int MAX_N = 64;

  // Index width for n lines, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  // Number of set bits; narrower vectors are zero-extended by the caller.
  function automatic int unsigned popcount(input logic [MAX_N-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_N; i++) begin
      cnt = cnt + {31'b0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/first_one_idx.sv
// rtl/first_one_idx.sv - combinational lowest-set-bit finder with found flag
module first_one_idx
  import prio_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_grant_reg.sv
// rtl/prio_grant_reg.sv - registered priority grant with valid/ready hold; PRIO_GRANT_ROUND_ROBIN_EN selects round-robin search
module prio_grant_reg
  import prio_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req,
  input  logic                    out_ready,
  output logic [clog2_min1(N)-1:0] z,
  output logic                    z_valid,
  output logic                    z_multi
);

  localparam int IW = clog2_min1(N);

  logic [IW-1:0]    z_q, z_d;
  logic             z_valid_q, z_valid_d;
  logic             z_multi_q, z_multi_d;
  logic             cap;
  logic [IW-1:0]    win_idx;
  logic             win_found;
  logic [MAX_N-1:0] req_wide;

  logic [IW-1:0] all_idx;
  logic          all_found;

  first_one_idx #(.N(N), .IW(IW)) u_all (
    .vec   (req),
    .idx   (all_idx),
    .found (all_found)
  );

`ifdef PRIO_GRANT_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  req_hi;
  logic [IW-1:0] hi_idx;
  logic          hi_found;

  // Keep only requests strictly above the last grant so the search resumes after it.
  always_comb begin
    req_hi = '0;
    for (int i = 0; i < N; i++) begin
      if (i > int'(ptr_q)) req_hi[i] = req[i];
    end
  end

  first_one_idx #(.N(N), .IW(IW)) u_hi (
    .vec   (req_hi),
    .idx   (hi_idx),
    .found (hi_found)
  );

  // Prefer a winner above the pointer; otherwise wrap to the lowest set bit.
  always_comb begin
    win_idx   = hi_found ? hi_idx : all_idx;
    win_found = all_found;
  end

  // Pointer follows each successful capture only.
  always_comb begin
    ptr_d = ptr_q;
    if (cap && win_found) ptr_d = win_idx;
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: the lowest set bit wins outright.
  always_comb begin
    win_idx   = all_idx;
    win_found = all_found;
  end
`endif

  // Zero-extend the request vector for the shared popcount helper.
  always_comb begin
    req_wide         = '0;
    req_wide[N-1:0]  = req;
  end

  assign cap = !z_valid_q || out_ready;

  // Capture a new grant when the slot is free or being consumed; z holds on empty captures.
  always_comb begin
    z_d       = z_q;
    z_valid_d = z_valid_q;
    z_multi_d = z_multi_q;
    if (cap) begin
      if (win_found) begin
        z_d       = win_idx;
        z_valid_d = 1'b1;
        z_multi_d = (popcount(req_wide) > 1);
      end else begin
        z_valid_d = 1'b0;
        z_multi_d = 1'b0;
      end
    end
  end

  // Output registers; reset drops any pending grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q       <= '0;
      z_valid_q <= 1'b0;
      z_multi_q <= 1'b0;
    end else begin
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      z_multi_q <= z_multi_d;
    end
  end

  assign z       = z_q;
  assign z_valid = z_valid_q;
  assign z_multi = z_multi_q;

endmodule

// File: tb/tb_prio_grant_reg.sv
// tb/tb_prio_grant_reg.sv - self-checking bench for prio_grant_reg in either priority mode
module tb_prio_grant_reg;

  localparam int N = 4;
`ifdef PRIO_GRANT_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         out_ready;
  logic [1:0]   z;
  logic         z_valid;
  logic         z_multi;

  int total = 0;
  int bad   = 0;

  // Reference state: what the consumer should see, plus the last granted index.
  logic [1:0] m_z;
  logic       m_v;
  logic       m_m;
  int         m_ptr;

  always #5 clk = ~clk;

  prio_grant_reg #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .z         (z),
    .z_valid   (z_valid),
    .z_multi   (z_multi)
  );

  task automatic model_edge(input logic [N-1:0] r, input logic rdy, input logic rs);
    int win;
    int j;
    bit hit;
    if (rs) begin
      m_z = 0; m_v = 0; m_m = 0; m_ptr = 0;
    end else if (!m_v || rdy) begin
      if (r == 0) begin
        m_v = 0; m_m = 0;
      end else begin
        hit = 0;
        win = 0;
        for (int k = 0; k < N; k++) begin
          j = RR_MODE ? (m_ptr + 1 + k) % N : k;
          if (!hit && r[j]) begin
            win = j;
            hit = 1;
          end
        end
        m_z   = 2'(win);
        m_v   = 1;
        m_m   = ($countones(r) > 1);
        m_ptr = win;
      end
    end
  endtask

  task automatic tick(input logic [N-1:0] r, input logic rdy, input logic rs);
    req       = r;
    out_ready = rdy;
    rst       = rs;
    @(posedge clk);
    model_edge(r, rdy, rs);
    #1;
  endtask

  task automatic test_reset;
    for (int c = 0; c < 2; c++) begin
      tick(4'b1111, 1'b1, 1'b1);
      total++;
      if ({z, z_valid, z_multi} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got z=%0d v=%0b m=%0b want 0/0/0", c, z, z_valid, z_multi);
      end
    end
    tick(4'b1111, 1'b1, 1'b0);
    total++;
    if (z !== (RR_MODE ? 2'd1 : 2'd0) || z_valid !== 1'b1 || z_multi !== 1'b1) begin
      bad++;
      $display("FAIL reset_first_cap got z=%0d v=%0b m=%0b want z=%0d v=1 m=1", z, z_valid, z_multi, RR_MODE ? 1 : 0);
    end
  endtask

  task automatic test_fixed_sweep;
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      r = '0;
      r[i] = 1'b1;
      tick(r, 1'b1, 1'b0);
      total++;
      if (z !== 2'(i) || z_valid !== 1'b1 || z_multi !== 1'b0) begin
        bad++;
        $display("FAIL sweep i=%0d got z=%0d v=%0b m=%0b want z=%0d v=1 m=0", i, z, z_valid, z_multi, i);
      end
    end
    tick(4'b0000, 1'b1, 1'b0);
    total++;
    if (z !== 2'd3 || z_valid !== 1'b0 || z_multi !== 1'b0) begin
      bad++;
      $display("FAIL sweep_empty got z=%0d v=%0b m=%0b want z=3 v=0 m=0", z, z_valid, z_multi);
    end
  endtask

  task automatic test_stall;
    tick(4'b0100, 1'b0, 1'b0);
    total++;
    if (z !== 2'd2 || z_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_cap got z=%0d v=%0b want z=2 v=1", z, z_valid);
    end
    for (int c = 0; c < 3; c++) begin
      tick(4'b0001, 1'b0, 1'b0);
      total++;
      if (z !== 2'd2 || z_valid !== 1'b1 || z_multi !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got z=%0d v=%0b m=%0b want z=2 v=1 m=0", c, z, z_valid, z_multi);
      end
    end
    tick(4'b0001, 1'b1, 1'b0);
    total++;
    if (z !== 2'd0 || z_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_release got z=%0d v=%0b want z=0 v=1", z, z_valid);
    end
  endtask

  task automatic test_multi;
    tick(4'b0000, 1'b1, 1'b1);
    tick(4'b1010, 1'b1, 1'b0);
    total++;
    if (z !== 2'd1 || z_valid !== 1'b1 || z_multi !== 1'b1) begin
      bad++;
      $display("FAIL multi_1010 got z=%0d v=%0b m=%0b want z=1 v=1 m=1", z, z_valid, z_multi);
    end
    tick(4'b1000, 1'b1, 1'b0);
    total++;
    if (z !== 2'd3 || z_valid !== 1'b1 || z_multi !== 1'b0) begin
      bad++;
      $display("FAIL multi_1000 got z=%0d v=%0b m=%0b want z=3 v=1 m=0", z, z_valid, z_multi);
    end
  endtask

  task automatic test_reset_mid;
    tick(4'b0100, 1'b1, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    total++;
    if (z !== 2'd2 || z_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pending got z=%0d v=%0b want z=2 v=1", z, z_valid);
    end
    tick(4'b0100, 1'b0, 1'b1);
    total++;
    if (z !== 2'd0 || z_valid !== 1'b0 || z_multi !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_drop got z=%0d v=%0b m=%0b want 0/0/0", z, z_valid, z_multi);
    end
    tick(4'b0000, 1'b0, 1'b0);
    total++;
    if (z !== 2'd0 || z_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_after got z=%0d v=%0b want z=0 v=0", z, z_valid);
    end
  endtask

  task automatic test_round_robin;
    int exp_all [6];
    int exp_19  [3];
    if (RR_MODE) begin
      exp_all = '{1, 2, 3, 0, 1, 2};
      exp_19  = '{3, 0, 3};
    end else begin
      exp_all = '{0, 0, 0, 0, 0, 0};
      exp_19  = '{0, 0, 0};
    end
    tick(4'b0000, 1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      tick(4'b1111, 1'b1, 1'b0);
      total++;
      if (z !== 2'(exp_all[c]) || z_valid !== 1'b1 || z_multi !== 1'b1) begin
        bad++;
        $display("FAIL rr_1111 step=%0d got z=%0d v=%0b m=%0b want z=%0d v=1 m=1", c, z, z_valid, z_multi, exp_all[c]);
      end
    end
    tick(4'b0000, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick(4'b1001, 1'b1, 1'b0);
      total++;
      if (z !== 2'(exp_19[c]) || z_valid !== 1'b1) begin
        bad++;
        $display("FAIL rr_1001 step=%0d got z=%0d v=%0b want z=%0d v=1", c, z, z_valid, exp_19[c]);
      end
    end
  endtask

  task automatic test_random;
    logic [N-1:0] r;
    logic         rdy;
    logic         rs;
    for (int c = 0; c < 400; c++) begin
      r   = N'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 99) < 60);
      rs  = ($urandom_range(0, 99) < 2);
      tick(r, rdy, rs);
      total++;
      if (z !== m_z || z_valid !== m_v || z_multi !== m_m) begin
        bad++;
        $display("FAIL random cyc=%0d req=%b rdy=%0b rst=%0b got z=%0d v=%0b m=%0b want z=%0d v=%0b m=%0b",
                 c, r, rdy, rs, z, z_valid, z_multi, m_z, m_v, m_m);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    m_z = 0; m_v = 0; m_m = 0; m_ptr = 0;
    test_reset;
    test_fixed_sweep;
    test_stall;
    test_multi;
    test_reset_mid;
    test_round_robin;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
